avg_tree_pipe: RTL and testbench

- Parametrised, pipelined successor to the two-input halving add `p2` in `pack_me`: averages N_IN signed samples of WIDTH bits through a binary tree of halving adders, one registered tree level per stage.
- Sits after sample capture in the AM demodulator datapath, for example envelope smoothing across channel or tap groups.
- Valid/ready streaming on both sides, with per-stage bubble collapsing and full-throughput operation.

---
 rtl/avg_tree_pipe.sv | 88 ++++++++
 tb/tb_avg_tree_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/avg_tree_pipe.sv
// Pipelined binary tree of halving adders averaging N_IN signed samples, one tree level per stage.
// Define AVG_ROUND_EN for round-half-up halving; the default build truncates (floor).
module avg_tree_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_IN  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
);

  localparam int unsigned L     = $clog2(N_IN);
  localparam int unsigned NodeW = (2 * N_IN - 1) * WIDTH;
  localparam int unsigned RegW  = (N_IN - 1) * WIDTH;
  localparam int          NIn   = N_IN;
  localparam int          Wd    = WIDTH;

`ifdef AVG_ROUND_EN
  localparam logic [WIDTH:0] RndInc = {{WIDTH{1'b0}}, 1'b1};
`else
  localparam logic [WIDTH:0] RndInc = '0;
`endif

  // Sum on WIDTH+1 bits cannot overflow, so dropping the LSB is an exact halving.
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b} + RndInc;
    return s[WIDTH:1];
  endfunction

  logic [L:0]       v;
  logic [L:1]       valid_q, valid_d;
  logic [L+1:1]     en;
  logic [RegW-1:0]  tree_q, tree_d;
  logic [NodeW-1:0] nodes;

  // Whole tree as one node vector: level 0 (inputs) at the bottom, the root at the top.
  assign v     = {valid_q, in_valid};
  assign nodes = {tree_q, in_data};

  always_comb begin
    en       = '0;
    en[L+1]  = out_ready;
    for (int k = L; k >= 1; k--) begin
      en[k] = ~v[k] | en[k+1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 1; k <= L; k++) begin
      if (en[k]) valid_d[k] = v[k-1];
    end
  end

  always_comb begin
    tree_d = tree_q;
    for (int k = 1; k <= L; k++) begin
      if (en[k]) begin
        for (int j = 0; j < (NIn >> k); j++) begin
          tree_d[(NIn - 2 * (NIn >> k) + j) * Wd +: WIDTH] =
            halve(nodes[(2 * NIn - 4 * (NIn >> k) + 2 * j) * Wd +: WIDTH],
                  nodes[(2 * NIn - 4 * (NIn >> k) + 2 * j + 1) * Wd +: WIDTH]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tree_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tree_q  <= tree_d;
    end
  end

  assign in_ready  = en[1];
  assign out_valid = valid_q[L];
  assign out_data  = tree_q[RegW-1 -: WIDTH];

endmodule

// File: tb/tb_avg_tree_pipe.sv
// Self-checking bench for avg_tree_pipe (WIDTH=16, N_IN=8): directed cases plus a randomized
// stream scored against an arithmetic tree-average model.
module tb_avg_tree_pipe;

  localparam int W = 16;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;

  avg_tree_pipe #(.WIDTH(W), .N_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  logic         acc  = 1'b0;
  logic         fire = 1'b0;
  int           lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int h(input int a, input int b);
    int s;
    s = a + b;
`ifdef AVG_ROUND_EN
    s = s + 1;
`endif
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  function automatic logic [W-1:0] model(input logic [N*W-1:0] vec);
    int vals[$];
    int nxt[$];
    for (int i = 0; i < N; i++) vals.push_back(int'($signed(vec[i*W +: W])));
    while (vals.size() > 1) begin
      nxt.delete();
      for (int i = 0; i < vals.size(); i += 2) nxt.push_back(h(vals[i], vals[i+1]));
      vals = nxt;
    end
    return W'(vals[0]);
  endfunction

  // Sample handshakes just after the falling edge, score them, then advance one clock.
  task automatic cycle();
    logic [W-1:0] e;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 32'(out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
    if (acc) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic send(input logic [N*W-1:0] vec, input logic [W-1:0] e);
    in_data  = vec;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) break;
    end
    chk("accept_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (fire) break;
      n++;
    end
    chk("output_timeout", 32'(fire), 32'(1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  logic [N*W-1:0] vec;
  logic [W-1:0]   r_one, r_neg, r_31;

  initial begin
`ifdef AVG_ROUND_EN
    r_one = 16'd1; r_neg = 16'd0;      r_31 = 16'd1;
`else
    r_one = 16'd0; r_neg = 16'hFFFF;   r_31 = 16'd0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cur_exp = '0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_data", 32'(out_data), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;

    // Constant vector: latency L, then the pipe empties.
    out_ready = 1'b1;
    send({N{16'd100}}, 16'd100);
    wait_out(lat);
    chk("const_latency", 32'(lat), 32'(3));
    #1 chk("const_valid_drop", 32'(out_valid), 32'(0));

    // Extremes back to back.
    send({N{16'h7FFF}}, 16'h7FFF);
    send({N{16'h8000}}, 16'h8000);
    drain();

    // Rounding behaviour of the cascade.
    vec = '0; vec[15:0] = 16'd1;    send(vec, r_one);
    vec = '0; vec[15:0] = 16'hFFFF; send(vec, r_neg);
    vec = '0; vec[15:0] = 16'd3; vec[31:16] = 16'd1; send(vec, r_31);
    drain();

    // Backpressure: three fill the pipe, the fourth is held.
    out_ready = 1'b0;
    send({N{16'd10}}, 16'd10);
    send({N{16'd20}}, 16'd20);
    send({N{16'd30}}, 16'd30);
    in_data = {N{16'd40}}; cur_exp = 16'd40; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_out_stable", 32'(out_data), 32'(10));
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_accept_40", 32'(acc), 32'(1));
    chk("bp_out_cycle0", 32'(fire), 32'(1));
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cycle();
      chk("bp_out_consecutive", 32'(fire), 32'(1));
    end
    chk("bp_empty", 32'(exp_q.size()), 32'(0));

    // Bubble collapse: 5 stalled at the output, 7 still enters.
    out_ready = 1'b0;
    send({N{16'd5}}, 16'd5);
    for (int i = 0; i < 3; i++) cycle();
    #1 chk("bubble_stalled_valid", 32'(out_valid), 32'(1));
    chk("bubble_in_ready", 32'(in_ready), 32'(1));
    send({N{16'd7}}, 16'd7);
    cycle();
    drain();

    // Reset with three vectors in flight.
    out_ready = 1'b1;
    send({N{16'd1}}, 16'd1);
    send({N{16'd2}}, 16'd2);
    send({N{16'd3}}, 16'd3);
    out_ready = 1'b0;
    #1 chk("rst_inflight_valid", 32'(out_valid), 32'(1));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'(0));
    chk("rst_async_data", 32'(out_data), 32'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rst_no_stale_output", 32'(out_valid), 32'(0));
      @(negedge clk);
    end
    send({N{16'd9}}, 16'd9);
    wait_out(lat);
    chk("rst_after_latency", 32'(lat), 32'(3));

    // Random stream with random backpressure.
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 9) == 0) in_data = {N{16'h8000}};
        cur_exp  = model(in_data);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
